// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared encodings for the L1-to-L2 bus scheduler
package cache_bus_pkg;

    localparam int ADDR_W_DEF = 26;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_RFO   = 2'd2,
        CMD_INVAL = 2'd3
    } bus_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        REQ_D  = 2'd0,
        REQ_I  = 2'd1,
        REQ_WB = 2'd2
    } req_id_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - dirty-victim writeback queue with per-entry address match
module wb_fifo
    import cache_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [ADDR_W-1:0] i_i_addr,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_d_match,
    output logic              o_i_match
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_overflow;
    logic              w_pop_ok;
    logic              w_push_ok;

    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign o_overflow  = r_overflow;
    assign o_head_addr = r_mem[r_rd_ptr];
    assign w_pop_ok    = i_pop && !o_empty;
    assign w_push_ok   = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            // When full, the push lands in the slot being popped, so it must win.
            if (w_push_ok) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_addr;
        end
    end

    always_comb begin
        o_d_match = 1'b0;
        o_i_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[k] && (r_mem[k] == i_d_addr)) o_d_match = 1'b1;
            if (r_valid[k] && (r_mem[k] == i_i_addr)) o_i_match = 1'b1;
        end
    end

endmodule

// File: rtl/l2_bus_scheduler.sv
// rtl/l2_bus_scheduler.sv - arbitrates D-cache, I-cache and writeback traffic onto the L2 command bus
module l2_bus_scheduler
    import cache_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WB_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              d_req,
    input  logic [1:0]        d_cmd,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_done,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    input  logic              wb_push,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              wb_full,
    output logic              wb_overflow,
    output logic              bus_valid,
    output logic [1:0]        command_to_L2,
    output logic [ADDR_W-1:0] addr_to_L2,
    input  logic              bus_ready,
    output logic [CNT_W-1:0]  ops_count,
    output logic [CNT_W-1:0]  hazard_count
);
    sched_state_e      r_state, w_next_state;
    req_id_e           r_winner, w_next_winner;
    logic              r_rr_i, w_next_rr_i;
    logic              r_bus_valid, w_next_valid;
    logic [1:0]        r_cmd, w_next_cmd;
    logic [ADDR_W-1:0] r_addr, w_next_addr;
    logic              r_d_done, w_next_d_done;
    logic              r_i_done, w_next_i_done;
    logic [CNT_W-1:0]  r_ops, w_next_ops;
    logic [CNT_W-1:0]  r_haz, w_next_haz;

    logic              w_pop;
    logic [ADDR_W-1:0] w_wb_head;
    logic              w_wb_empty, w_wb_full, w_wb_overflow;
    logic              w_d_match, w_i_match;
    logic              w_d_elig, w_i_elig, w_hazard;

    wb_fifo #(.ADDR_W(ADDR_W), .DEPTH(WB_DEPTH)) u_wb_fifo (
        .clk         (Clock),
        .rst_n       (clear),
        .i_push      (wb_push),
        .i_push_addr (wb_addr),
        .i_pop       (w_pop),
        .i_d_addr    (d_addr),
        .i_i_addr    (i_addr),
        .o_head_addr (w_wb_head),
        .o_empty     (w_wb_empty),
        .o_full      (w_wb_full),
        .o_overflow  (w_wb_overflow),
        .o_d_match   (w_d_match),
        .o_i_match   (w_i_match)
    );

    // A request still visible during its own done pulse is the finished one, not a new one.
    assign w_d_elig = d_req && !r_d_done;
    assign w_i_elig = i_req && !r_i_done;
    assign w_hazard = (w_d_elig && (d_cmd == CMD_READ || d_cmd == CMD_RFO) && w_d_match)
                   || (w_i_elig && w_i_match);

    always_comb begin
        w_next_state  = r_state;
        w_next_winner = r_winner;
        w_next_rr_i   = r_rr_i;
        w_next_valid  = r_bus_valid;
        w_next_cmd    = r_cmd;
        w_next_addr   = r_addr;
        w_next_d_done = 1'b0;
        w_next_i_done = 1'b0;
        w_next_ops    = r_ops;
        w_next_haz    = r_haz;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_wb_empty && (w_wb_full || w_hazard)) begin
                    w_next_winner = REQ_WB;
                    w_next_cmd    = CMD_WRITE;
                    w_next_addr   = w_wb_head;
                    w_next_valid  = 1'b1;
                    w_next_state  = ST_ISSUE;
                    if (w_hazard) w_next_haz = r_haz + 1'b1;
                end else if (w_d_elig && (!w_i_elig || !r_rr_i)) begin
                    w_next_winner = REQ_D;
                    w_next_cmd    = d_cmd;
                    w_next_addr   = d_addr;
                    w_next_valid  = 1'b1;
                    w_next_rr_i   = 1'b1;
                    w_next_state  = ST_ISSUE;
                end else if (w_i_elig) begin
                    w_next_winner = REQ_I;
                    w_next_cmd    = CMD_READ;
                    w_next_addr   = i_addr;
                    w_next_valid  = 1'b1;
                    w_next_rr_i   = 1'b0;
                    w_next_state  = ST_ISSUE;
                end else if (!w_wb_empty) begin
                    w_next_winner = REQ_WB;
                    w_next_cmd    = CMD_WRITE;
                    w_next_addr   = w_wb_head;
                    w_next_valid  = 1'b1;
                    w_next_state  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus_ready) begin
                    w_next_ops   = r_ops + 1'b1;
                    w_pop        = (r_winner == REQ_WB);
                    w_next_valid = 1'b0;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_d_done = (r_winner == REQ_D);
                w_next_i_done = (r_winner == REQ_I);
                w_next_state  = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_state     <= ST_IDLE;
            r_winner    <= REQ_D;
            r_rr_i      <= 1'b0;
            r_bus_valid <= 1'b0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_d_done    <= 1'b0;
            r_i_done    <= 1'b0;
            r_ops       <= '0;
            r_haz       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_winner    <= w_next_winner;
            r_rr_i      <= w_next_rr_i;
            r_bus_valid <= w_next_valid;
            r_cmd       <= w_next_cmd;
            r_addr      <= w_next_addr;
            r_d_done    <= w_next_d_done;
            r_i_done    <= w_next_i_done;
            r_ops       <= w_next_ops;
            r_haz       <= w_next_haz;
        end
    end

    assign d_done        = r_d_done;
    assign i_done        = r_i_done;
    assign bus_valid     = r_bus_valid;
    assign command_to_L2 = r_cmd;
    assign addr_to_L2    = r_addr;
    assign ops_count     = r_ops;
    assign hazard_count  = r_haz;
    assign wb_full       = w_wb_full;
    assign wb_overflow   = w_wb_overflow;

endmodule

// File: tb/tb_l2_bus_scheduler.sv
// tb/tb_l2_bus_scheduler.sv - self-checking bench for l2_bus_scheduler
module tb_l2_bus_scheduler;
    localparam int ADDR_W = 26;
    localparam int CNT_W  = 32;

    logic              Clock, clear;
    logic              d_req, i_req, wb_push, bus_ready;
    logic [1:0]        d_cmd;
    logic [ADDR_W-1:0] d_addr, i_addr, wb_addr;
    logic              d_done, i_done, wb_full, wb_overflow, bus_valid;
    logic [1:0]        command_to_L2;
    logic [ADDR_W-1:0] addr_to_L2;
    logic [CNT_W-1:0]  ops_count, hazard_count;

    int checks, errors;
    logic [ADDR_W+1:0] acc_q[$];

    l2_bus_scheduler #(.ADDR_W(ADDR_W), .WB_DEPTH(4), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .clear(clear),
        .d_req(d_req), .d_cmd(d_cmd), .d_addr(d_addr), .d_done(d_done),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .wb_push(wb_push), .wb_addr(wb_addr), .wb_full(wb_full), .wb_overflow(wb_overflow),
        .bus_valid(bus_valid), .command_to_L2(command_to_L2), .addr_to_L2(addr_to_L2),
        .bus_ready(bus_ready), .ops_count(ops_count), .hazard_count(hazard_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic idle_inputs();
        d_req = 0; d_cmd = 0; d_addr = 0; i_req = 0; i_addr = 0;
        wb_push = 0; wb_addr = 0; bus_ready = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        clear = 0;
        repeat (2) @(negedge Clock);
        clear = 1;
        @(negedge Clock);
        acc_q.delete();
    endtask

    // Records the operation the coming rising edge will accept, then advances one cycle.
    task automatic tick();
        if (bus_valid && bus_ready) acc_q.push_back({command_to_L2, addr_to_L2});
        @(negedge Clock);
    endtask

    task automatic test_reset();
        idle_inputs();
        clear = 0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({bus_valid, d_done, i_done, wb_overflow, wb_full} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {bus_valid, d_done, i_done, wb_overflow, wb_full});
        end
        checks++;
        if (command_to_L2 !== 2'd0 || addr_to_L2 !== '0) begin
            errors++; $display("FAIL reset_bus got cmd %h addr %h exp 0 0", command_to_L2, addr_to_L2);
        end
        checks++;
        if (ops_count !== 0 || hazard_count !== 0) begin
            errors++; $display("FAIL reset_counters got ops %0d haz %0d exp 0 0", ops_count, hazard_count);
        end
        clear = 1;
        @(negedge Clock);
    endtask

    task automatic test_single_read();
        apply_reset();
        bus_ready = 1; d_req = 1; d_cmd = 2'd0; d_addr = 26'h0001234;
        @(negedge Clock);
        checks++;
        if (bus_valid !== 1'b1 || command_to_L2 !== 2'd0 || addr_to_L2 !== 26'h0001234) begin
            errors++; $display("FAIL single_issue got v %b cmd %h addr %h exp 1 0 0001234", bus_valid, command_to_L2, addr_to_L2);
        end
        @(negedge Clock);
        checks++;
        if (bus_valid !== 1'b0 || d_done !== 1'b0) begin
            errors++; $display("FAIL single_accept got v %b done %b exp 0 0", bus_valid, d_done);
        end
        @(negedge Clock);
        checks++;
        if (d_done !== 1'b1 || i_done !== 1'b0) begin
            errors++; $display("FAIL single_done got d %b i %b exp 1 0", d_done, i_done);
        end
        d_req = 0;
        @(negedge Clock);
        checks++;
        if (d_done !== 1'b0 || bus_valid !== 1'b0 || ops_count !== 1) begin
            errors++; $display("FAIL single_after got done %b v %b ops %0d exp 0 0 1", d_done, bus_valid, ops_count);
        end
    endtask

    task automatic test_round_robin();
        logic [ADDR_W+1:0] exp;
        apply_reset();
        bus_ready = 1;
        d_req = 1; d_cmd = 2'd0; d_addr = 26'h0000D01;
        i_req = 1; i_addr = 26'h0000101;
        for (int k = 0; k < 40 && acc_q.size() < 4; k++) tick();
        idle_inputs();
        repeat (4) @(negedge Clock);
        checks++;
        if (acc_q.size() < 4) begin
            errors++; $display("FAIL rr_count got %0d exp 4", acc_q.size());
        end
        for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
            exp = (k % 2 == 0) ? {2'd0, 26'h0000D01} : {2'd0, 26'h0000101};
            checks++;
            if (acc_q[k] !== exp) begin
                errors++; $display("FAIL rr_grant%0d got %h exp %h", k, acc_q[k], exp);
            end
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        bus_ready = 1;
        wb_push = 1; wb_addr = 26'h00000AB;
        tick();
        wb_push = 0;
        d_req = 1; d_cmd = 2'd2; d_addr = 26'h00000AB;
        for (int k = 0; k < 40 && d_req; k++) begin
            tick();
            if (d_done) d_req = 0;
        end
        repeat (3) tick();
        checks++;
        if (acc_q.size() != 2) begin
            errors++; $display("FAIL hazard_count_ops got %0d exp 2", acc_q.size());
        end else begin
            checks++;
            if (acc_q[0] !== {2'd1, 26'h00000AB} || acc_q[1] !== {2'd2, 26'h00000AB}) begin
                errors++; $display("FAIL hazard_order got %h %h exp %h %h", acc_q[0], acc_q[1],
                                   {2'd1, 26'h00000AB}, {2'd2, 26'h00000AB});
            end
        end
        checks++;
        if (hazard_count !== 1 || ops_count !== 2) begin
            errors++; $display("FAIL hazard_counters got haz %0d ops %0d exp 1 2", hazard_count, ops_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            wb_push = 1; wb_addr = 26'(32'h100 + k);
            @(negedge Clock);
            checks++;
            if (wb_full !== (k >= 3) || wb_overflow !== (k == 4)) begin
                errors++; $display("FAIL ovf_push%0d got full %b ovf %b exp %b %b", k, wb_full, wb_overflow, k >= 3, k == 4);
            end
        end
        wb_push = 0; bus_ready = 1;
        repeat (30) tick();
        checks++;
        if (acc_q.size() != 4) begin
            errors++; $display("FAIL ovf_drain_count got %0d exp 4", acc_q.size());
        end
        for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
            checks++;
            if (acc_q[k] !== {2'd1, 26'(32'h100 + k)}) begin
                errors++; $display("FAIL ovf_drain%0d got %h exp %h", k, acc_q[k], {2'd1, 26'(32'h100 + k)});
            end
        end
        checks++;
        if (wb_full !== 1'b0 || wb_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got full %b ovf %b exp 0 1", wb_full, wb_overflow);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [ADDR_W-1:0] exp_addr [5];
        exp_addr = '{26'h200, 26'h201, 26'h202, 26'h203, 26'h2FF};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            wb_push = 1; wb_addr = 26'(32'h200 + k);
            @(negedge Clock);
        end
        checks++;
        if (wb_full !== 1'b1 || bus_valid !== 1'b1) begin
            errors++; $display("FAIL pp_prefull got full %b v %b exp 1 1", wb_full, bus_valid);
        end
        wb_push = 1; wb_addr = 26'h2FF; bus_ready = 1;
        tick();
        wb_push = 0;
        checks++;
        if (wb_full !== 1'b1 || wb_overflow !== 1'b0) begin
            errors++; $display("FAIL pp_same_cycle got full %b ovf %b exp 1 0", wb_full, wb_overflow);
        end
        repeat (30) tick();
        checks++;
        if (acc_q.size() != 5) begin
            errors++; $display("FAIL pp_drain_count got %0d exp 5", acc_q.size());
        end
        for (int k = 0; k < 5 && k < acc_q.size(); k++) begin
            checks++;
            if (acc_q[k] !== {2'd1, exp_addr[k]}) begin
                errors++; $display("FAIL pp_drain%0d got %h exp %h", k, acc_q[k], {2'd1, exp_addr[k]});
            end
        end
    endtask

    task automatic test_clear_mid_issue();
        apply_reset();
        bus_ready = 1; d_req = 1; d_cmd = 2'd0; d_addr = 26'h3000;
        for (int k = 0; k < 10 && !d_done; k++) @(negedge Clock);
        bus_ready = 0; d_addr = 26'h3200; wb_push = 1; wb_addr = 26'h3100;
        @(negedge Clock);
        wb_push = 0;
        @(negedge Clock);
        checks++;
        if (bus_valid !== 1'b1 || ops_count !== 1) begin
            errors++; $display("FAIL clr_pre got v %b ops %0d exp 1 1", bus_valid, ops_count);
        end
        #2 clear = 0;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || ops_count !== 0 || hazard_count !== 0 || wb_full !== 1'b0 || d_done !== 1'b0) begin
            errors++; $display("FAIL clr_async got v %b ops %0d haz %0d full %b done %b exp 0 0 0 0 0",
                               bus_valid, ops_count, hazard_count, wb_full, d_done);
        end
        d_req = 0;
        @(negedge Clock);
        clear = 1;
        acc_q.delete();
        bus_ready = 1;
        repeat (4) tick();
        checks++;
        if (acc_q.size() != 0 || bus_valid !== 1'b0) begin
            errors++; $display("FAIL clr_fifo_empty got ops %0d v %b exp 0 0", acc_q.size(), bus_valid);
        end
        d_req = 1; d_cmd = 2'd0; d_addr = 26'h3400;
        for (int k = 0; k < 10 && !d_done; k++) tick();
        d_req = 0;
        tick();
        checks++;
        if (acc_q.size() != 1 || ops_count !== 1) begin
            errors++; $display("FAIL clr_after_count got q %0d ops %0d exp 1 1", acc_q.size(), ops_count);
        end else begin
            checks++;
            if (acc_q[0] !== {2'd0, 26'h3400}) begin
                errors++; $display("FAIL clr_after_op got %h exp %h", acc_q[0], {2'd0, 26'h3400});
            end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] wbq[$];
        logic [ADDR_W-1:0] e_addr, c_daddr, c_iaddr, c_waddr;
        logic [1:0]        e_cmd, c_dcmd;
        logic              c_dreq, c_ireq, c_push, c_ready;
        logic              p_valid, p_ddone, p_idone, d_ok, i_ok, haz, popped, exp_ovf, quiet;
        int who, rr_i, exp_ops, exp_haz, exp_dd, exp_id, got_dd, got_id;
        apply_reset();
        c_dreq = 0; c_ireq = 0; c_push = 0; c_ready = 0; c_dcmd = 0;
        c_daddr = 0; c_iaddr = 0; c_waddr = 0;
        p_valid = 0; p_ddone = 0; p_idone = 0; exp_ovf = 0;
        e_cmd = 0; e_addr = 0;
        who = -1; rr_i = 0; exp_ops = 0; exp_haz = 0; exp_dd = 0; exp_id = 0; got_dd = 0; got_id = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            popped = 0;
            if (!p_valid && bus_valid) begin
                d_ok = c_dreq && !p_ddone;
                i_ok = c_ireq && !p_idone;
                haz  = 0;
                foreach (wbq[k]) begin
                    if (d_ok && (c_dcmd == 2'd0 || c_dcmd == 2'd2) && wbq[k] == c_daddr) haz = 1;
                    if (i_ok && wbq[k] == c_iaddr) haz = 1;
                end
                if (wbq.size() > 0 && (haz || wbq.size() == 4)) begin
                    who = 2;
                    if (haz) exp_haz++;
                end else if (d_ok && (!i_ok || rr_i == 0)) begin
                    who = 0; rr_i = 1;
                end else if (i_ok) begin
                    who = 1; rr_i = 0;
                end else if (wbq.size() > 0) begin
                    who = 2;
                end else begin
                    who = -1;
                end
                e_cmd  = (who == 0) ? c_dcmd : (who == 1) ? 2'd0 : 2'd1;
                e_addr = (who == 0) ? c_daddr : (who == 1) ? c_iaddr : (who == 2) ? wbq[0] : '0;
                checks++;
                if (who < 0 || command_to_L2 !== e_cmd || addr_to_L2 !== e_addr) begin
                    errors++; $display("FAIL rand_grant cyc %0d got cmd %h addr %h exp who %0d cmd %h addr %h",
                                       cyc, command_to_L2, addr_to_L2, who, e_cmd, e_addr);
                end
            end else if (p_valid && bus_valid) begin
                checks++;
                if (command_to_L2 !== e_cmd || addr_to_L2 !== e_addr) begin
                    errors++; $display("FAIL rand_hold cyc %0d got %h %h exp %h %h", cyc, command_to_L2, addr_to_L2, e_cmd, e_addr);
                end
            end
            if (p_valid && c_ready) begin
                exp_ops++;
                if (who == 0) exp_dd++;
                else if (who == 1) exp_id++;
                else if (who == 2 && wbq.size() > 0) begin
                    void'(wbq.pop_front());
                    popped = 1;
                end
            end
            if (c_push) begin
                if (wbq.size() < 4 || popped) wbq.push_back(c_waddr);
                else exp_ovf = 1;
            end
            if (d_done) got_dd++;
            if (i_done) got_id++;
            checks++;
            if (wb_full !== (wbq.size() == 4) || wb_overflow !== exp_ovf) begin
                errors++; $display("FAIL rand_fifo cyc %0d got full %b ovf %b exp %b %b", cyc, wb_full, wb_overflow, wbq.size() == 4, exp_ovf);
            end
            p_valid = bus_valid; p_ddone = d_done; p_idone = i_done;
            quiet = (cyc >= 1200);
            if (d_done) d_req = 0;
            else if (!d_req && !quiet && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_cmd = 2'($urandom_range(0, 3)); d_addr = 26'(32'h40 + $urandom_range(0, 7));
            end
            if (i_done) i_req = 0;
            else if (!i_req && !quiet && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = 26'(32'h40 + $urandom_range(0, 7));
            end
            wb_push   = !quiet && ($urandom_range(0, 3) == 0);
            wb_addr   = 26'(32'h40 + $urandom_range(0, 7));
            bus_ready = quiet || ($urandom_range(0, 1) == 1);
            c_dreq = d_req; c_dcmd = d_cmd; c_daddr = d_addr; c_ireq = i_req; c_iaddr = i_addr;
            c_push = wb_push; c_waddr = wb_addr; c_ready = bus_ready;
            @(negedge Clock);
        end
        checks++;
        if (ops_count !== exp_ops || hazard_count !== exp_haz) begin
            errors++; $display("FAIL rand_counters got ops %0d haz %0d exp %0d %0d", ops_count, hazard_count, exp_ops, exp_haz);
        end
        checks++;
        if (got_dd != exp_dd || got_id != exp_id) begin
            errors++; $display("FAIL rand_dones got d %0d i %0d exp %0d %0d", got_dd, got_id, exp_dd, exp_id);
        end
        checks++;
        if (wbq.size() != 0 || bus_valid !== 1'b0 || d_req || i_req) begin
            errors++; $display("FAIL rand_drain got q %0d v %b dreq %b ireq %b exp 0 0 0 0", wbq.size(), bus_valid, d_req, i_req);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear  = 0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_hazard();
        test_overflow();
        test_push_pop_same_cycle();
        test_clear_mid_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
